// File: rtl/dup_test_arbiter_pkg.sv
// rtl/dup_test_arbiter_pkg.sv - shared types and constants for the dupTestSt round-robin arbiter
package dup_test_arbiter_pkg;

  localparam int DSIZE2          = 2;
  localparam int DUP_ARB_NUM_REQ = 4;
  localparam int BOB_W           = 13;

  typedef struct packed {
    logic [BOB_W-1:0] bob;
  } dupTestSt;

  typedef logic [3:0] dupArbBeatCntT;

  typedef enum logic {
    DUP_ARB_IDLE,
    DUP_ARB_GRANT
  } dupArbStateT;

endpackage

// File: rtl/dup_test_arbiter_rr_pick.sv
// rtl/dup_test_arbiter_rr_pick.sv - combinational masked round-robin priority encoder
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic [SRC_W-1:0]   gnt_o,
  output logic               any_req_o
);

  // Second pass overrides the unmasked winner whenever a requester at or after ptr_i exists.
  always_comb begin
    gnt_o     = '0;
    any_req_o = |req_i;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) gnt_o = SRC_W'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i] && (SRC_W'(i) >= ptr_i)) gnt_o = SRC_W'(i);
    end
  end

endmodule

// File: rtl/dup_test_arbiter.sv
// rtl/dup_test_arbiter.sv - round-robin burst arbiter onto one registered dupTestSt sink
// Optional grant statistics output enabled by DUP_TEST_ARB_STATS_EN.
module dup_test_arbiter
  import dup_test_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DUP_ARB_NUM_REQ,
  parameter int BURST_LEN = DSIZE2,
  parameter int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  dupTestSt [NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output dupTestSt                  out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready,
`ifdef DUP_TEST_ARB_STATS_EN
  output logic [NUM_REQ-1:0][15:0]  grant_cnt,
`endif
  output logic                      busy
);

  localparam dupArbBeatCntT    BEAT_LAST = dupArbBeatCntT'(BURST_LEN);
  localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ - 1);

  dupArbStateT      state_q, state_d;
  logic [SRC_W-1:0] gnt_q, gnt_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  dupArbBeatCntT    beat_cnt_q, beat_cnt_d;
  logic             out_valid_q, out_valid_d;
  dupTestSt         out_data_q, out_data_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;

  logic [SRC_W-1:0] pick_gnt;
  logic             any_req;
  logic             out_free;
  logic             accept;
  logic [SRC_W-1:0] rr_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (pick_gnt),
    .any_req_o (any_req)
  );

  assign out_free = !out_valid_q || out_ready;
  assign accept   = (state_q == DUP_ARB_GRANT) && req_valid[gnt_q] && out_free;
  assign rr_next  = (gnt_q == LAST_IDX) ? '0 : gnt_q + SRC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DUP_ARB_IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Release on a full burst or when the granted requester has nothing to offer this cycle.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      DUP_ARB_IDLE: begin
        if (any_req) begin
          state_d = DUP_ARB_GRANT;
          gnt_d   = pick_gnt;
        end
      end
      DUP_ARB_GRANT: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + dupArbBeatCntT'(1);
          if (beat_cnt_d == BEAT_LAST) begin
            state_d    = DUP_ARB_IDLE;
            rr_ptr_d   = rr_next;
            beat_cnt_d = '0;
          end
        end else if (!req_valid[gnt_q]) begin
          state_d    = DUP_ARB_IDLE;
          rr_ptr_d   = rr_next;
          beat_cnt_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == DUP_ARB_GRANT) req_ready[gnt_q] = out_free;
    busy = (state_q == DUP_ARB_GRANT) || out_valid_q;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data[gnt_q];
      out_src_d   = gnt_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef DUP_TEST_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else if ((state_q == DUP_ARB_IDLE) && any_req && (grant_cnt_q[pick_gnt] != 16'hFFFF)) begin
      grant_cnt_q[pick_gnt] <= grant_cnt_q[pick_gnt] + 16'd1;
    end
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_dup_test_arbiter.sv
// tb/tb_dup_test_arbiter.sv - scoreboard bench for the round-robin dupTestSt arbiter
module tb_dup_test_arbiter;
  import dup_test_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0]  src;
    logic [12:0] bob;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_valid;
  dupTestSt [3:0] req_data;
  logic [3:0]     req_ready;
  logic           out_valid;
  dupTestSt       out_data;
  logic [1:0]     out_src;
  logic           out_ready;
  logic           busy;
`ifdef DUP_TEST_ARB_STATS_EN
  logic [3:0][15:0] grant_cnt;
`endif

  exp_t        sb[$];
  logic [12:0] rq[4][$];
  int          hs_cyc[$];
  int          cyc;
  int          n_total;
  int          n_bad;
  logic        hold_chk;
  exp_t        hold_val;

  dup_test_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
`ifdef DUP_TEST_ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]    = 1'b1;
        req_data[i].bob = rq[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = '0;
      end
    end
  endtask

  task automatic push_req(input int i, input logic [12:0] d);
    rq[i].push_back(d);
  endtask

  task automatic push_exp(input int i, input logic [12:0] d);
    exp_t e;
    e.src = 2'(i);
    e.bob = d;
    sb.push_back(e);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) rq[i].delete();
  endtask

  task automatic cycle();
    logic [3:0] acc;
    exp_t       e;
    @(negedge clk);
    acc = req_valid & req_ready;
    chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
    if (hold_chk) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_bob", 32'(out_data.bob), 32'(hold_val.bob));
      chk("hold_src", 32'(out_src), 32'(hold_val.src));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    if (out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_src", 32'(out_src), 32'(e.src));
        chk("out_bob", 32'(out_data.bob), 32'(e.bob));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    drive();
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 200 && sb.size() > 0; k++) cycle();
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_out_valid(input string tag);
    for (int k = 0; k < 20 && !out_valid; k++) cycle();
    chk({tag, "_valid_seen"}, 32'(out_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_bob"}, 32'(out_data.bob), 32'd0);
    chk({tag, "_out_src"}, 32'(out_src), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    cyc       = 0;
    hold_chk  = 1'b0;
    out_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;

    do_reset();
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;

    // Single requester: 2-beat burst, one arbitration gap, then the third beat.
    hs_cyc.delete();
    push_req(0, 13'h0AA); push_req(0, 13'h0AB); push_req(0, 13'h0AC);
    push_exp(0, 13'h0AA); push_exp(0, 13'h0AB); push_exp(0, 13'h0AC);
    drive();
    drain("single");
    @(negedge clk);
    chk("single_busy_after", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("single_hs_count", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() >= 3) begin
      chk("single_gap_burst", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
      chk("single_gap_idle", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
    end

    // All four requesting: pairs in order 0,1,2,3 then wrap back to 0.
    do_reset();
    hs_cyc.delete();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) push_req(i, 13'(i * 16 + k));
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++)
        for (int k = 2 * p; k < 2 * p + 2; k++) push_exp(i, 13'(i * 16 + k));
    drive();
    drain("all");
    chk("all_hs_count", 32'(hs_cyc.size()), 32'd16);
    if (hs_cyc.size() == 16) begin
      for (int k = 1; k < 16; k++)
        chk("all_gap", 32'(hs_cyc[k] - hs_cyc[k-1]), (k % 2 == 1) ? 32'd1 : 32'd2);
    end

    // Backpressure mid-burst for 5 cycles.
    for (int k = 0; k < 4; k++) begin
      push_req(1, 13'(13'h200 + k));
      push_exp(1, 13'(13'h200 + k));
    end
    drive();
    wait_out_valid("bp");
    hold_val  = sb[0];
    out_ready = 1'b0;
    hold_chk  = 1'b1;
    repeat (5) cycle();
    hold_chk  = 1'b0;
    out_ready = 1'b1;
    drain("bp");

    // Withdraw after one beat: pointer moves past requester 2, so 3 beats 0.
    push_req(2, 13'h300);
    push_req(3, 13'h301); push_req(3, 13'h302);
    push_req(0, 13'h303);
    push_exp(2, 13'h300); push_exp(3, 13'h301); push_exp(3, 13'h302); push_exp(0, 13'h303);
    drive();
    drain("withdraw");

    // Reset while a beat is pending at the output.
    push_req(3, 13'h400); push_req(3, 13'h401);
    drive();
    wait_out_valid("rstmid");
    out_ready = 1'b0;
    rst       = 1'b1;
    cycle();
    @(negedge clk);
    chk_all_zero("rstmid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_reqs();
    sb.delete();
    push_req(0, 13'h500); push_req(3, 13'h501);
    push_exp(0, 13'h500); push_exp(3, 13'h501);
    out_ready = 1'b1;
    drive();
    drain("rstmid");

`ifdef DUP_TEST_ARB_STATS_EN
    chk("stats_g0", 32'(grant_cnt[0]), 32'd1);
    chk("stats_g1", 32'(grant_cnt[1]), 32'd0);
    chk("stats_g2", 32'(grant_cnt[2]), 32'd0);
    chk("stats_g3", 32'(grant_cnt[3]), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dup_test_arbiter.md
Name: dup_test_arbiter

Overview:
- Round-robin arbiter that shares one dupTestSt sink between NUM_REQ independent valid/ready requesters.
- Each grant is held for up to BURST_LEN accepted beats, then priority rotates.
- Output is a single registered stage that carries the winning requester's index.
- Sits in front of the mixedNestedInclude consumer of dupTestSt (13-bit field bob).

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- BURST_LEN, DSIZE2 (2): maximum beats accepted per grant before forced rotation; legal range 1..15.
- SRC_W, $clog2(NUM_REQ): width of the source index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester valid.
- req_data  in  NUM_REQ x dupTestSt  per-requester payload; element i belongs to requester i.
- req_ready  out  NUM_REQ  per-requester ready.
- out_valid  out  1  output beat valid.
- out_data  out  dupTestSt  output payload.
- out_src  out  SRC_W  index of the requester that produced the beat.
- out_ready  in  1  downstream ready.
- busy  out  1  high when state is GRANT or out_valid is high.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, beat_cnt=0, out_valid=0, out_data=0, out_src=0, req_ready=0, busy=0.
- States:
  - IDLE: no grant held. If any req_valid is high, select the first requester at or after rr_ptr (wrapping modulo NUM_REQ), latch it as gnt, and go to GRANT the next cycle. The arbitration cycle accepts no data.
  - GRANT: req_ready[gnt] = (!out_valid | out_ready). All other req_ready bits are 0. req_ready is combinational from the registered state and out_ready.
- Accept: req_valid[gnt] & req_ready[gnt]. On accept, the next cycle has out_valid=1, out_data=req_data[gnt], out_src=gnt, and beat_cnt increments. Latency is 1 cycle.
- Full throughput: back-to-back accepts while out_ready stays high.
- Output hold: with out_valid=1 and out_ready=0, out_data and out_src are stable and no accept occurs.
- Output drain: out_valid clears after out_valid & out_ready unless a new accept happens in the same cycle.
- Grant release, from GRANT to IDLE with rr_ptr=(gnt+1) mod NUM_REQ and beat_cnt=0, occurs when either:
  - an accept makes beat_cnt reach BURST_LEN, or
  - req_valid[gnt]=0 in a cycle with no accept (requester withdrew or paused).
- Rotation guarantees no requester waits longer than (NUM_REQ-1) grants.
- Simultaneous release and new requests: the IDLE arbitration cycle is always taken. That gives 1 dead cycle per grant, which is accepted cost.
- Single requester: that requester is re-granted after each IDLE cycle. Sustained rate is BURST_LEN/(BURST_LEN+1).
- Requesters must not drop valid without a handshake (AXI-style). If one does, the withdraw rule above releases the grant without error.
- Reset mid-burst: a pending output beat is discarded, and state returns to reset values on the next edge.
- beat_cnt width is 4 bits. It never wraps because release happens at BURST_LEN.

Optional Feature:
- Macro: DUP_TEST_ARB_STATS_EN.
- Defined: adds output grant_cnt [NUM_REQ x 16]. Entry i increments on each IDLE->GRANT transition that selects requester i, saturates at 16'hFFFF, and clears on rst.
- Not defined: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Add to mixedNestedInclude_package:
  - localparam DUP_ARB_NUM_REQ=4.
  - typedef logic[3:0] dupArbBeatCntT.
  - enum dupArbStateT {DUP_ARB_IDLE, DUP_ARB_GRANT}.
- Reuse the existing dupTestSt and DSIZE2.
- One sub-module, rr_pick: a purely combinational masked round-robin priority encoder. Inputs: req vector and rr_ptr. Outputs: gnt index and any_req.

Test Plan:
- Single requester: rst, then req_valid=4'b0001, bob=13'h0AA, 13'h0AB, 13'h0AC, out_ready=1 → beats out_src=0 in order. IDLE gap after the 2nd beat (BURST_LEN=2). busy drops 1 cycle after the last output handshake.
- All four requesting continuously, out_ready=1 → grant order 0,0,1,1,2,2,3,3,0, one idle cycle between pairs. No requester gets 3 consecutive beats.
- Backpressure: out_ready=0 for 5 cycles mid-burst → out_valid=1, out_data and out_src stable, req_ready=0. Resuming drains with no loss or duplication.
- Withdraw: requester 2 granted, drops req_valid after 1 beat → next cycle IDLE, rr_ptr=3, requester 3 granted next if valid.
- Reset mid-burst: assert rst while out_valid=1 → next cycle all outputs 0, and rr_ptr=0 (requester 0 wins first).
- With DUP_TEST_ARB_STATS_EN: all-request scenario for 40 cycles → grant_cnt entries differ by at most 1. Forcing count 16'hFFFE → saturates at 16'hFFFF.
